edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N, default 4, number of monitored input channels (2..16).
REQ-002 Parameter IW, default $clog2(N), width of evt_id.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  N  raw level inputs, one per channel, already synchronous to clk.
REQ-006 cfg_mode  input  2*N  per-channel detect mode, bits [2i+1:2i]: 00 disabled, 01 rising edge, 10 falling edge, 11 one-cycle pulse (010).
REQ-007 ovf_clr  input  1  single-cycle pulse; clears all sticky overflow flags.
REQ-008 evt_ready  input  1  downstream accepts the current event.
REQ-009 evt_valid  output  1  event available on evt_id.
REQ-010 evt_id  output  IW  index of the channel that produced the event.
REQ-011 overflow  output  N  sticky per-channel event-lost flags.

Function
REQ-012 Each channel keeps a 2-bit history of a[i] (previous and previous-but-one cycles), updated every cycle regardless of mode.
REQ-013 Detection is combinational in cycle t: rising = a[i]=1 and prev=0; falling = a[i]=0 and prev=1; pulse = a[i]=0, prev=1, prev-but-one=0.
REQ-014 Mode 00 shall suppress detection; pending[i] shall read 0 from the cycle after mode becomes 00.
REQ-015 A detection in cycle t shall set pending[i], visible from cycle t+1.
REQ-016 Output slot (evt_valid, evt_id) is a register; it loads when (evt_valid=0 or evt_ready=1) and any pending bit is set.
REQ-017 Load selects the first set pending bit at or after rr_ptr, searching upward modulo N; the selected pending bit is cleared in the same edge.
REQ-018 After a load with channel k, rr_ptr shall become (k+1) mod N.
REQ-019 Minimum latency: detection in cycle t, evt_valid=1 in cycle t+2.
REQ-020 While evt_valid=1 and evt_ready=0, evt_valid and evt_id shall hold stable.
REQ-021 evt_valid=1 and evt_ready=1 with no pending bits shall clear evt_valid on the next edge; with pending bits, next event loads back-to-back (no bubble).
REQ-022 A channel whose event sits in the output slot may set pending again; that is not an overflow.
REQ-023 Detection on channel i while pending[i]=1 and pending[i] not being cleared by a load in the same cycle shall set overflow[i]; the event is dropped.
REQ-024 Detection on channel i in the same cycle its pending bit is loaded shall leave pending[i]=1 and shall not set overflow[i].
REQ-025 ovf_clr and a new overflow condition in the same cycle: set wins, overflow[i]=1.
REQ-026 cfg_mode changes take effect on detection in the same cycle they are applied; history is not reset.
REQ-027 evt_ready while evt_valid=0 shall be ignored.

Reset
REQ-028 rst=1 shall clear history, pending, overflow, evt_valid, evt_id (0) and rr_ptr (0) on the next edge.
REQ-029 rst asserted mid-transfer shall discard the output-slot event and all pending events; no event appears until a new detection after rst deasserts.
REQ-030 History is 00 after reset, so a[i]=1 in the first cycle after reset is a rising edge in mode 01.

Verification
REQ-031 N=4, ch0 mode 01, evt_ready=1, a[0] 0->1 at cycle 5 -> evt_valid=1, evt_id=0 at cycle 7 only, single cycle.
REQ-032 ch2 mode 11, a[2] sequence 0,1,0 -> one event id 2; sequence 0,1,1,0 -> no event; same with mode 10 -> event on the 1->0.
REQ-033 All four channels mode 01, simultaneous rising edges, evt_ready=1 -> ids 0,1,2,3 on consecutive cycles; repeat with rr_ptr=2 -> 2,3,0,1.
REQ-034 evt_ready=0, ch1 edges at cycles 3, 6, 9 -> slot holds id 1, pending[1] set, third edge sets overflow[1]; ovf_clr pulse clears it; ovf_clr same cycle as new overflow -> overflow stays 1.
REQ-035 Event stalled (evt_valid=1, evt_ready=0) plus pending on ch3, assert rst for 1 cycle -> evt_valid=0, overflow=0, no event emitted afterwards without new edge.
REQ-036 ch0 pending, set cfg_mode ch0 to 00 -> pending[0] cleared next cycle, no event for ch0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Per-channel edge/pulse detector feeding a round-robin arbiter into one registered output slot.
// Latency: detection in cycle t gives evt_valid in t+2. A stalled slot holds; a repeat event on a pending channel is dropped and flagged.
module edge_event_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    a,
   input  logic [2*N-1:0]  cfg_mode,
   input  logic            ovf_clr,
   input  logic            evt_ready,
   output logic            evt_valid,
   output logic [IW-1:0]   evt_id,
   output logic [N-1:0]    overflow
);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_RISE  = 2'b01;
   localparam logic [1:0] MODE_FALL  = 2'b10;
   localparam logic [1:0] MODE_PULSE = 2'b11;

   logic [N-1:0]   hist_p1;
   logic [N-1:0]   hist_p2;
   logic [N-1:0]   pending;
   logic [IW-1:0]  rr_ptr;

   logic [N-1:0]   rise;
   logic [N-1:0]   fall;
   logic [N-1:0]   pulse;
   logic [N-1:0]   det;
   logic [N-1:0]   enabled;
   logic [N-1:0]   eligible;
   logic [2*N-1:0] rotated;
   logic [N-1:0]   sel_oh;
   logic [N-1:0]   clr_oh;
   logic [N-1:0]   pending_nxt;
   logic [N-1:0]   ovf_set;
   logic [IW-1:0]  sel_id;
   logic [IW-1:0]  rr_nxt;
   logic           found;
   logic           load;

   assign rise  = a & ~hist_p1;
   assign fall  = ~a & hist_p1;
   assign pulse = ~a & hist_p1 & ~hist_p2;

   always_comb begin
      det     = '0;
      enabled = '0;
      for (int i = 0; i < N; i++) begin
         case (cfg_mode[2*i +: 2])
            MODE_RISE:  det[i] = rise[i];
            MODE_FALL:  det[i] = fall[i];
            MODE_PULSE: det[i] = pulse[i];
            default:    det[i] = 1'b0;
         endcase
         enabled[i] = (cfg_mode[2*i +: 2] != MODE_OFF);
      end
   end

   // A disabled channel can neither win arbitration nor keep its pending bit.
   assign eligible = pending & enabled;
   assign rotated  = {eligible, eligible} >> rr_ptr;

   always_comb begin
      int off;
      int sum;
      int nxt;
      found = 1'b0;
      off   = 0;
      for (int i = 0; i < N; i++) begin
         if (!found && rotated[i]) begin
            found = 1'b1;
            off   = i;
         end
      end
      sum = int'(rr_ptr) + off;
      if (sum >= N) begin
         sum = sum - N;
      end
      nxt = sum + 1;
      if (nxt >= N) begin
         nxt = 0;
      end
      sel_id = IW'(sum);
      rr_nxt = IW'(nxt);
      sel_oh = {{(N-1){1'b0}}, 1'b1} << sel_id;
   end

   assign load   = (~evt_valid | evt_ready) & found;
   assign clr_oh = load ? sel_oh : '0;

   // A fresh detection on the channel being loaded re-arms pending instead of overflowing.
   assign ovf_set     = det & pending & ~clr_oh;
   assign pending_nxt = ((pending & ~clr_oh) | det) & enabled;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_p1   <= '0;
         hist_p2   <= '0;
         pending   <= '0;
         overflow  <= '0;
         evt_valid <= 1'b0;
         evt_id    <= '0;
         rr_ptr    <= '0;
      end else begin
         hist_p2  <= hist_p1;
         hist_p1  <= a;
         pending  <= pending_nxt;
         overflow <= (overflow & ~{N{ovf_clr}}) | ovf_set;
         if (load) begin
            evt_valid <= 1'b1;
            evt_id    <= sel_id;
            rr_ptr    <= rr_nxt;
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against a behavioural event-queue model.
module tb_edge_event_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   a;
   logic [2*N-1:0] cfg_mode;
   logic           ovf_clr;
   logic           evt_ready;
   logic           evt_valid;
   logic [IW-1:0]  evt_id;
   logic [N-1:0]   overflow;

   int n_vec = 0;
   int n_err = 0;

   bit         m_h1   [N];
   bit         m_h2   [N];
   bit         m_pend [N];
   logic [N-1:0] m_ovf;
   bit         m_vld;
   int         m_id;
   int         m_rr;

   always #5 clk = ~clk;

   edge_event_arbiter #(.N(N), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .cfg_mode  (cfg_mode),
      .ovf_clr   (ovf_clr),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .overflow  (overflow)
   );

   function automatic int mode_of(int c);
      return int'((cfg_mode >> (2*c)) & 8'd3);
   endfunction

   function automatic bit in_of(int c);
      return ((a >> c) & 4'd1) != 4'd0;
   endfunction

   // One clock of the reference: events queue per channel, one slot, round-robin pick.
   task automatic model_step();
      bit det [N];
      bit ld;
      int k;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_h1[i] = 0; m_h2[i] = 0; m_pend[i] = 0;
         end
         m_ovf = '0; m_vld = 0; m_id = 0; m_rr = 0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         case (mode_of(i))
            1: det[i] = in_of(i) && !m_h1[i];
            2: det[i] = !in_of(i) && m_h1[i];
            3: det[i] = !in_of(i) && m_h1[i] && !m_h2[i];
            default: det[i] = 0;
         endcase
      end
      ld = 0;
      k  = 0;
      if (!m_vld || evt_ready) begin
         for (int s = 0; s < N; s++) begin
            int c;
            c = (m_rr + s) % N;
            if (!ld && m_pend[c] && mode_of(c) != 0) begin
               ld = 1;
               k  = c;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         bit taken;
         bit lost;
         bit np;
         taken = ld && (i == k);
         lost  = det[i] && m_pend[i] && !taken;
         np    = (m_pend[i] && !taken) || det[i];
         if (mode_of(i) == 0) np = 0;
         m_pend[i] = np;
         if (lost) m_ovf = m_ovf | (4'd1 << i);
         else if (ovf_clr) m_ovf = m_ovf & ~(4'd1 << i);
         m_h2[i] = m_h1[i];
         m_h1[i] = in_of(i);
      end
      if (ld) begin
         m_vld = 1;
         m_id  = k;
         m_rr  = (k + 1) % N;
      end else if (evt_ready) begin
         m_vld = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ovf_clr = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      cfg_mode = 8'h55; evt_ready = 1'b1; a = 4'hF;
      do_reset();
      n_vec++;
      if (evt_valid !== 1'b0 || evt_id !== 2'd0 || overflow !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state: got v=%b id=%0d ovf=%b, want v=0 id=0 ovf=0000", evt_valid, evt_id, overflow);
      end
      for (int cyc = 0; cyc < 8; cyc++) begin
         logic ev;
         ev = (cyc >= 2 && cyc <= 5);
         n_vec++;
         if (evt_valid !== ev || (ev && evt_id !== IW'(cyc - 2))) begin
            n_err++;
            $display("FAIL reset_first_rise cyc %0d: got v=%b id=%0d, want v=%b id=%0d", cyc, evt_valid, evt_id, ev, cyc - 2);
         end
         n_vec++;
         if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL reset_model cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
         end
         tick();
      end
   endtask

   task automatic test_single_edge();
      cfg_mode = 8'b0000_0001; evt_ready = 1'b1; a = 4'h0;
      do_reset();
      for (int cyc = 0; cyc < 11; cyc++) begin
         n_vec++;
         if (evt_valid !== (cyc == 7) || (cyc == 7 && evt_id !== 2'd0)) begin
            n_err++;
            $display("FAIL single_edge cyc %0d: got v=%b id=%0d, want v=%b id=0", cyc, evt_valid, evt_id, cyc == 7);
         end
         n_vec++;
         if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL single_edge_model cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
         end
         a = (cyc >= 5) ? 4'h1 : 4'h0;
         tick();
      end
   endtask

   task automatic test_modes();
      logic [7:0] seqs  [3] = '{8'b0000_0010, 8'b0000_0110, 8'b0000_0110};
      logic [1:0] modes [3] = '{2'b11, 2'b11, 2'b10};
      int         want  [3] = '{1, 0, 1};
      for (int sc = 0; sc < 3; sc++) begin
         int cnt;
         cnt = 0;
         cfg_mode = {2'b00, modes[sc], 4'b0000}; evt_ready = 1'b1; a = 4'h0;
         do_reset();
         for (int cyc = 0; cyc < 11; cyc++) begin
            if (evt_valid === 1'b1 && evt_id === 2'd2) cnt++;
            n_vec++;
            if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
               n_err++;
               $display("FAIL modes_model sc %0d cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", sc, cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
            end
            a = (((seqs[sc] >> cyc) & 8'd1) != 8'd0) ? 4'b0100 : 4'b0000;
            tick();
         end
         n_vec++;
         if (cnt != want[sc]) begin
            n_err++;
            $display("FAIL modes_count sc %0d: got %0d events, want %0d", sc, cnt, want[sc]);
         end
      end
   endtask

   task automatic test_simultaneous();
      int ids   [$];
      int cycs  [$];
      int w_ids [9] = '{0, 1, 2, 3, 1, 2, 3, 0, 1};
      int w_cyc [9] = '{3, 4, 5, 6, 11, 15, 16, 17, 18};
      cfg_mode = 8'h55; evt_ready = 1'b1; a = 4'h0;
      do_reset();
      for (int cyc = 0; cyc < 22; cyc++) begin
         if (evt_valid === 1'b1) begin
            ids.push_back(int'(evt_id));
            cycs.push_back(cyc);
         end
         n_vec++;
         if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL simul_model cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
         end
         if (cyc >= 1 && cyc <= 7) a = 4'hF;
         else if (cyc >= 9 && cyc <= 11) a = 4'h2;
         else if (cyc >= 13) a = 4'hF;
         else a = 4'h0;
         tick();
      end
      n_vec++;
      if (ids.size() != 9) begin
         n_err++;
         $display("FAIL simul_count: got %0d events, want 9", ids.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (ids[i] != w_ids[i] || cycs[i] != w_cyc[i]) begin
               n_err++;
               $display("FAIL simul_order #%0d: got id %0d at cyc %0d, want id %0d at cyc %0d", i, ids[i], cycs[i], w_ids[i], w_cyc[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      cfg_mode = 8'b0000_0100; evt_ready = 1'b0; a = 4'h0;
      do_reset();
      for (int cyc = 0; cyc < 18; cyc++) begin
         logic ov;
         ov = (cyc == 10 || cyc == 11 || cyc >= 15);
         n_vec++;
         if (overflow !== {2'b00, ov, 1'b0} || evt_valid !== (cyc >= 5) || (cyc >= 5 && evt_id !== 2'd1)) begin
            n_err++;
            $display("FAIL overflow cyc %0d: got ovf=%b v=%b id=%0d, want ovf=%b v=%b id=1", cyc, overflow, evt_valid, evt_id, {2'b00, ov, 1'b0}, cyc >= 5);
         end
         n_vec++;
         if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL overflow_model cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
         end
         a = (cyc == 3 || cyc == 6 || cyc == 9 || cyc == 14) ? 4'b0010 : 4'b0000;
         ovf_clr = (cyc == 11 || cyc == 14);
         tick();
      end
      ovf_clr = 1'b0;
   endtask

   task automatic test_rst_mid();
      cfg_mode = 8'b0100_0001; evt_ready = 1'b0; a = 4'h0;
      do_reset();
      for (int cyc = 0; cyc < 22; cyc++) begin
         logic ev;
         ev = (cyc >= 3 && cyc <= 6);
         n_vec++;
         if (evt_valid !== ev || overflow !== 4'd0) begin
            n_err++;
            $display("FAIL rst_mid cyc %0d: got v=%b ovf=%b, want v=%b ovf=0000", cyc, evt_valid, overflow, ev);
         end
         n_vec++;
         if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL rst_mid_model cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
         end
         a = {(cyc == 4 || cyc == 5), 2'b00, (cyc >= 1 && cyc <= 4)};
         rst = (cyc == 6);
         evt_ready = (cyc >= 7);
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_mode_disable();
      int id0;
      id0 = 0;
      cfg_mode = 8'b0000_0101; evt_ready = 1'b0; a = 4'h0;
      do_reset();
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (evt_valid === 1'b1 && evt_id === 2'd0) id0++;
         n_vec++;
         if (cyc >= 9 && evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mode_disable_idle cyc %0d: got v=%b id=%0d, want v=0", cyc, evt_valid, evt_id);
         end
         n_vec++;
         if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL mode_disable_model cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
         end
         a = {2'b00, (cyc >= 1), (cyc >= 3)};
         if (cyc >= 5) cfg_mode = 8'b0000_0100;
         evt_ready = (cyc >= 8);
         tick();
      end
      n_vec++;
      if (id0 != 0) begin
         n_err++;
         $display("FAIL mode_disable_ch0: got %0d ch0 event cycles, want 0", id0);
      end
   endtask

   task automatic test_random();
      cfg_mode = 8'($urandom); evt_ready = 1'b1; a = 4'h0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         n_vec++;
         if (evt_valid !== m_vld || (m_vld && evt_id !== IW'(m_id)) || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL random_model cyc %0d: got v=%b id=%0d ovf=%b, want v=%b id=%0d ovf=%b", cyc, evt_valid, evt_id, overflow, m_vld, m_id, m_ovf);
         end
         a = 4'($urandom);
         if ($urandom_range(0, 9) == 0) cfg_mode = 8'($urandom);
         evt_ready = ($urandom_range(0, 9) < 6);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      ovf_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; a = '0; cfg_mode = '0; ovf_clr = 1'b0; evt_ready = 1'b0;
      m_ovf = '0; m_vld = 0; m_id = 0; m_rr = 0;
      @(negedge clk);
      test_reset();
      test_single_edge();
      test_modes();
      test_simultaneous();
      test_overflow();
      test_rst_mid();
      test_mode_disable();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
